// File: rtl/sim_ctrl.sv
// Simulation sequencer and pass/fail judge.
// Holds the core in reset for RST_HOLD cycles after bench reset. It then watches
// retirement and writeback to detect a branch-to-self halt, a global timeout or a
// retirement stall, and latches a sticky verdict.
module sim_ctrl #(
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned PASS_REG    = 10,
    parameter logic [31:0] PASS_VALUE  = 32'h0000_0001,
    parameter int unsigned HALT_REPEAT = 3,
    parameter int unsigned MAX_CYCLES  = 10000,
    parameter int unsigned STALL_LIMIT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cyc_cnt,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic        wb_valid,
    input  logic [4:0]  wb_idx,
    input  logic [31:0] wb_data,
    output logic        cpu_reset,
    output logic        passed,
    output logic        failed,
    output logic [1:0]  fail_code,
    output logic [31:0] fail_cycle
);

    localparam logic [31:0] HoldLast   = 32'(RST_HOLD - 1);
    localparam logic [31:0] HaltRep    = 32'(HALT_REPEAT);
    localparam logic [31:0] MaxCyc     = 32'(MAX_CYCLES);
    localparam logic [31:0] StallLim   = 32'(STALL_LIMIT);
    localparam logic [4:0]  PassRegIdx = 5'(PASS_REG);
    // Register x0 is hardwired to zero, so a shadow of it never loads.
    localparam bit          ShadowEn   = (PASS_REG != 0);

    localparam logic [1:0] CodeNone    = 2'd0;
    localparam logic [1:0] CodeWrong   = 2'd1;
    localparam logic [1:0] CodeTimeout = 2'd2;
    localparam logic [1:0] CodeStall   = 2'd3;

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StPass,
        StFail
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic [31:0] shadow_q, shadow_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        passed_q, passed_d;
    logic        failed_q, failed_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [31:0] fail_cycle_q, fail_cycle_d;
    logic        halt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Next-state, counter updates and verdict resolution.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        run_cnt_d    = run_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        last_pc_d    = last_pc_q;
        shadow_d     = shadow_q;
        passed_d     = passed_q;
        failed_d     = failed_q;
        fail_code_d  = fail_code_q;
        fail_cycle_d = fail_cycle_q;
        halt         = 1'b0;

        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end

            StRun: begin
                run_cnt_d   = sat_inc(run_cnt_q);
                stall_cnt_d = retire_valid ? 32'd0 : sat_inc(stall_cnt_q);

                if (ShadowEn && wb_valid && (wb_idx == PassRegIdx)) begin
                    shadow_d = wb_data;
                end

                // A zero repeat count marks "no PC retired yet in this run".
                if (retire_valid) begin
                    if ((rep_cnt_q != 32'd0) && (retire_pc == last_pc_q)) begin
                        rep_cnt_d = (rep_cnt_q >= HaltRep) ? rep_cnt_q : rep_cnt_q + 32'd1;
                    end else begin
                        rep_cnt_d = 32'd1;
                        last_pc_d = retire_pc;
                    end
                    halt = (rep_cnt_d >= HaltRep);
                end

                // Halt outranks timeout, which outranks stall.
                if (halt) begin
                    fail_cycle_d = cyc_cnt;
                    if (shadow_d == PASS_VALUE) begin
                        state_d  = StPass;
                        passed_d = 1'b1;
                    end else begin
                        state_d     = StFail;
                        failed_d    = 1'b1;
                        fail_code_d = CodeWrong;
                    end
                end else if (run_cnt_d >= MaxCyc) begin
                    state_d      = StFail;
                    failed_d     = 1'b1;
                    fail_code_d  = CodeTimeout;
                    fail_cycle_d = cyc_cnt;
                end else if (stall_cnt_d >= StallLim) begin
                    state_d      = StFail;
                    failed_d     = 1'b1;
                    fail_code_d  = CodeStall;
                    fail_cycle_d = cyc_cnt;
                end
            end

            // Verdict states are absorbing until reset.
            StPass: ;
            StFail: ;

            default: state_d = StHold;
        endcase

        cpu_reset_d = (state_d == StHold);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHold;
            hold_cnt_q   <= 32'd0;
            run_cnt_q    <= 32'd0;
            stall_cnt_q  <= 32'd0;
            rep_cnt_q    <= 32'd0;
            last_pc_q    <= 32'd0;
            shadow_q     <= 32'd0;
            cpu_reset_q  <= 1'b1;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            fail_code_q  <= CodeNone;
            fail_cycle_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            run_cnt_q    <= run_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            last_pc_q    <= last_pc_d;
            shadow_q     <= shadow_d;
            cpu_reset_q  <= cpu_reset_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            fail_code_q  <= fail_code_d;
            fail_cycle_q <= fail_cycle_d;
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign passed     = passed_q;
    assign failed     = failed_q;
    assign fail_code  = fail_code_q;
    assign fail_cycle = fail_cycle_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// Randomized self-checking bench for sim_ctrl against a queue-based verdict model.
module tb_sim_ctrl;

    localparam int          RH = 4;
    localparam int          PR = 10;
    localparam logic [31:0] PV = 32'h0000_0001;
    localparam int          HR = 3;
    localparam int          MC = 50;
    localparam int          SL = 8;
    localparam int          NMAX = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc_cnt = 32'd0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = 32'd0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_idx = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        cpu_reset;
    logic        passed;
    logic        failed;
    logic [1:0]  fail_code;
    logic [31:0] fail_cycle;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-RUN-cycle stimulus program.
    logic        s_rv[NMAX];
    logic [31:0] s_pc[NMAX];
    logic        s_wv[NMAX];
    logic [4:0]  s_idx[NMAX];
    logic [31:0] s_data[NMAX];
    logic [31:0] s_cyc[NMAX];

    sim_ctrl #(
        .RST_HOLD   (RH),
        .PASS_REG   (PR),
        .PASS_VALUE (PV),
        .HALT_REPEAT(HR),
        .MAX_CYCLES (MC),
        .STALL_LIMIT(SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cyc_cnt     (cyc_cnt),
        .retire_valid(retire_valid),
        .retire_pc   (retire_pc),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .cpu_reset   (cpu_reset),
        .passed      (passed),
        .failed      (failed),
        .fail_code   (fail_code),
        .fail_cycle  (fail_cycle)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int k = 0; k < NMAX; k++) begin
            s_rv[k]   = 1'b0;
            s_pc[k]   = 32'($urandom);
            s_wv[k]   = 1'b0;
            s_idx[k]  = 5'd0;
            s_data[k] = 32'd0;
            s_cyc[k]  = 32'($urandom);
        end
    endtask

    task automatic rand_wb(input int k);
        s_wv[k]   = 1'($urandom_range(0, 1));
        s_idx[k]  = ($urandom_range(0, 1) == 1) ? 5'(PR) : 5'($urandom_range(0, 31));
        s_data[k] = ($urandom_range(0, 1) == 1) ? PV : 32'($urandom_range(0, 3));
    endtask

    // Inputs that would halt-and-pass at once if they were not ignored.
    task automatic drive_junk();
        retire_valid = 1'b1;
        retire_pc    = 32'h40;
        wb_valid     = 1'b1;
        wb_idx       = 5'(PR);
        wb_data      = PV;
        cyc_cnt      = 32'($urandom);
    endtask

    task automatic drive_stim(input int k);
        retire_valid = s_rv[k];
        retire_pc    = s_pc[k];
        wb_valid     = s_wv[k];
        wb_idx       = s_idx[k];
        wb_data      = s_data[k];
        cyc_cnt      = s_cyc[k];
    endtask

    // Verdict model: halt means the last HR retired PCs are all equal.
    task automatic model(input int n, output int v, output logic ep, output logic [1:0] ec);
        logic [31:0] shadow;
        logic [31:0] hist[$];
        int          idle;
        bit          same;
        shadow = 32'd0;
        idle   = 0;
        v      = 0;
        ep     = 1'b0;
        ec     = 2'd0;
        for (int k = 0; k < n && v == 0; k++) begin
            if (s_wv[k] && s_idx[k] == 5'(PR) && PR != 0) shadow = s_data[k];
            same = 1'b0;
            if (s_rv[k]) begin
                hist.push_back(s_pc[k]);
                idle = 0;
                if (hist.size() >= HR) begin
                    same = 1'b1;
                    for (int i = 1; i < HR; i++)
                        if (hist[hist.size() - 1 - i] != s_pc[k]) same = 1'b0;
                end
            end else begin
                idle++;
            end
            if (same) begin
                v  = k + 1;
                ep = (shadow == PV);
                ec = ep ? 2'd0 : 2'd1;
            end else if (k + 1 >= MC) begin
                v  = k + 1;
                ec = 2'd2;
            end else if (idle >= SL) begin
                v  = k + 1;
                ec = 2'd3;
            end
        end
    endtask

    // Reset one cycle, step through HOLD, then play the program and check each cycle.
    task automatic run_program(input string name, input int n);
        int          v;
        logic        ep;
        logic [1:0]  ec;
        bit          done;
        logic        e_pass, e_fail;
        logic [1:0]  e_code;
        logic [31:0] e_cyc;
        model(n, v, ep, ec);

        @(negedge clk);
        reset = 1'b1;
        drive_junk();
        @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b1 || passed !== 1'b0 || failed !== 1'b0 ||
            fail_code !== 2'd0 || fail_cycle !== 32'd0) begin
            $display("FAIL %s reset_clear: cpu_reset=%0b passed=%0b failed=%0b code=%0d cyc=%h want 1 0 0 0 0",
                     name, cpu_reset, passed, failed, fail_code, fail_cycle);
        end else n_pass++;
        reset = 1'b0;
        drive_junk();

        for (int j = 1; j <= RH; j++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_reset !== (j < RH) || passed !== 1'b0 || failed !== 1'b0) begin
                $display("FAIL %s hold%0d: cpu_reset=%0b passed=%0b failed=%0b want %0b 0 0",
                         name, j, cpu_reset, passed, failed, (j < RH));
            end else n_pass++;
            if (j < RH) drive_junk();
        end

        for (int k = 0; k < n; k++) begin
            drive_stim(k);
            @(negedge clk);
            done   = (v != 0) && (k + 1 >= v);
            e_pass = done && ep;
            e_fail = done && !ep;
            e_code = e_fail ? ec : 2'd0;
            e_cyc  = e_fail ? s_cyc[v - 1] : 32'd0;
            n_checks++;
            if (passed !== e_pass || failed !== e_fail || cpu_reset !== 1'b0) begin
                $display("FAIL %s run%0d flags: passed=%0b failed=%0b cpu_reset=%0b want %0b %0b 0",
                         name, k + 1, passed, failed, cpu_reset, e_pass, e_fail);
            end else n_pass++;
            n_checks++;
            if (fail_code !== e_code) begin
                $display("FAIL %s run%0d fail_code: got %0d want %0d", name, k + 1, fail_code, e_code);
            end else n_pass++;
            if (!e_pass) begin
                n_checks++;
                if (fail_cycle !== e_cyc) begin
                    $display("FAIL %s run%0d fail_cycle: got %h want %h",
                             name, k + 1, fail_cycle, e_cyc);
                end else n_pass++;
            end
        end
        retire_valid = 1'b0;
        wb_valid     = 1'b0;
    endtask

    // Reset held through cycle 4, released at cycle 5: cpu_reset high to cycle 8.
    task automatic test_reset();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                n_checks++;
                if (cpu_reset !== (c <= 8) || passed !== 1'b0 || failed !== 1'b0) begin
                    $display("FAIL reset cycle%0d: cpu_reset=%0b passed=%0b failed=%0b want %0b 0 0",
                             c, cpu_reset, passed, failed, (c <= 8));
                end else n_pass++;
            end
            reset = (c < 5);
        end
    endtask

    // Random distinct-PC prefix, then a result writeback and a halt at hpc.
    task automatic build_halt(input logic [31:0] result, input logic [31:0] hpc, output int p);
        clear_stim();
        p = $urandom_range(0, 5);
        for (int k = 0; k < p; k++) begin
            s_rv[k] = 1'($urandom_range(0, 1));
            s_pc[k] = 32'h100 + 32'(4 * k);
            rand_wb(k);
        end
        s_wv[p]   = 1'b1;
        s_idx[p]  = 5'(PR);
        s_data[p] = result;
        for (int k = p + 1; k <= p + 3; k++) begin
            s_rv[k] = 1'b1;
            s_pc[k] = hpc;
        end
        for (int k = p + 4; k < NMAX; k++) begin
            s_rv[k] = 1'b1;
            s_pc[k] = 32'($urandom_range(0, 3)) * 4;
            rand_wb(k);
        end
    endtask

    task automatic test_pass();
        int p;
        build_halt(PV, 32'h40, p);
        run_program("pass", 30);
        n_checks++;
        if (passed !== 1'b1 || failed !== 1'b0 || fail_code !== 2'd0) begin
            $display("FAIL pass_final: passed=%0b failed=%0b code=%0d want 1 0 0",
                     passed, failed, fail_code);
        end else n_pass++;
    endtask

    task automatic test_wrong_result();
        int p;
        build_halt(32'h2, 32'h80, p);
        run_program("wrong", 30);
        n_checks++;
        if (failed !== 1'b1 || passed !== 1'b0 || fail_code !== 2'd1 || fail_cycle !== s_cyc[p + 3]) begin
            $display("FAIL wrong_final: failed=%0b passed=%0b code=%0d cyc=%h want 1 0 1 %h",
                     failed, passed, fail_code, fail_cycle, s_cyc[p + 3]);
        end else n_pass++;
    endtask

    task automatic test_timeout();
        clear_stim();
        for (int k = 0; k < NMAX; k++) begin
            s_rv[k] = 1'b1;
            s_pc[k] = (k % 2 == 0) ? 32'h10 : 32'h14;
            rand_wb(k);
        end
        run_program("timeout", 60);
        n_checks++;
        if (failed !== 1'b1 || fail_code !== 2'd2 || fail_cycle !== s_cyc[MC - 1]) begin
            $display("FAIL timeout_final: failed=%0b code=%0d cyc=%h want 1 2 %h",
                     failed, fail_code, fail_cycle, s_cyc[MC - 1]);
        end else n_pass++;
    endtask

    task automatic test_stall();
        clear_stim();
        for (int k = 0; k < NMAX; k++) rand_wb(k);
        run_program("stall", 20);
        n_checks++;
        if (failed !== 1'b1 || fail_code !== 2'd3 || fail_cycle !== s_cyc[SL - 1]) begin
            $display("FAIL stall_final: failed=%0b code=%0d cyc=%h want 1 3 %h",
                     failed, fail_code, fail_cycle, s_cyc[SL - 1]);
        end else n_pass++;
    endtask

    // Third same-PC retire lands on the MAX_CYCLES-th RUN cycle.
    task automatic test_halt_at_timeout();
        clear_stim();
        s_wv[0]   = 1'b1;
        s_idx[0]  = 5'(PR);
        s_data[0] = PV;
        for (int k = 0; k < MC - 3; k++) begin
            s_rv[k] = 1'b1;
            s_pc[k] = (k % 2 == 0) ? 32'h10 : 32'h14;
        end
        for (int k = MC - 3; k < NMAX; k++) begin
            s_rv[k] = 1'b1;
            s_pc[k] = 32'h200;
        end
        run_program("halt_timeout", 55);
        n_checks++;
        if (passed !== 1'b1 || failed !== 1'b0 || fail_code !== 2'd0) begin
            $display("FAIL halt_timeout_final: passed=%0b failed=%0b code=%0d want 1 0 0",
                     passed, failed, fail_code);
        end else n_pass++;
    endtask

    task automatic test_reset_from_fail();
        int p;
        test_stall();
        build_halt(PV, 32'h44, p);
        run_program("refail_pass", 30);
        n_checks++;
        if (passed !== 1'b1 || failed !== 1'b0) begin
            $display("FAIL refail_final: passed=%0b failed=%0b want 1 0", passed, failed);
        end else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            clear_stim();
            for (int k = 0; k < NMAX; k++) begin
                s_rv[k] = ($urandom_range(0, 3) != 0);
                s_pc[k] = 32'h40 + 32'(4 * $urandom_range(0, 2));
                rand_wb(k);
            end
            run_program("random", 60);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_wrong_result();
        test_timeout();
        test_stall();
        test_halt_at_timeout();
        test_reset_from_fail();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Simulation sequencer and pass/fail judge instantiated inside `top`, between the bench and the CPU core. It holds the core in reset for a programmable number of cycles after bench reset, then watches the retirement and register-writeback streams. It detects program completion (branch-to-self halt) and decides PASS or FAIL from a shadowed result register. It also catches global timeout and retirement stalls, and drives the `passed`/`failed` signals the bench acts on.

## Interface
Parameters:
- `RST_HOLD`, 4: cycles `cpu_reset` stays high after `reset` deasserts (≥1).
- `PASS_REG`, 10: architectural register index (0–31) holding the test result.
- `PASS_VALUE`, 32'h0000_0001: value in `PASS_REG` that means success.
- `HALT_REPEAT`, 3: consecutive retirements at the same PC that constitute a halt (≥2).
- `MAX_CYCLES`, 10000: RUN-state cycle budget before timeout.
- `STALL_LIMIT`, 256: cycles in RUN with no retirement before stall failure.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `cyc_cnt` in 32: bench cycle counter, used only for capture.
- `retire_valid` in 1: one instruction retired this cycle.
- `retire_pc` in 32: PC of retired instruction.
- `wb_valid` in 1: register writeback this cycle.
- `wb_idx` in 5: writeback destination register.
- `wb_data` in 32: writeback value.
- `cpu_reset` out 1: reset to the core.
- `passed` out 1: sticky success.
- `failed` out 1: sticky failure.
- `fail_code` out 2: 0 none, 1 wrong result, 2 timeout, 3 stall.
- `fail_cycle` out 32: `cyc_cnt` captured on the verdict cycle.

## Operation
- FSM states: HOLD, RUN, PASS, FAIL.
- `reset` high: state HOLD, hold counter 0, all other counters 0, shadow 0, `cpu_reset`=1, `passed`=0, `failed`=0, `fail_code`=0, `fail_cycle`=0.
- HOLD: counter increments each cycle. When it reaches `RST_HOLD`−1, go to RUN. `cpu_reset`=1 throughout HOLD and 0 in every other state.
- RUN:
  - Run counter increments every cycle.
  - Stall counter clears on `retire_valid` and increments otherwise.
  - `wb_valid && wb_idx==PASS_REG` loads `wb_data` into the shadow. If `PASS_REG`==0, the shadow stays 0.
  - Halt tracking, on `retire_valid`:
    - If `retire_pc` equals the last retired PC, increment the repeat count (saturating at `HALT_REPEAT`).
    - Otherwise set the repeat count to 1 and record the PC.
    - The first retirement after RUN entry sets the count to 1.
  - Halt is true when the repeat count reaches `HALT_REPEAT`.
- RUN verdict, evaluated each cycle on updated values, in priority order:
  1. Halt: go to PASS if the shadow (including a writeback in the same cycle) equals `PASS_VALUE`; otherwise go to FAIL with code 1.
  2. Run counter reaches `MAX_CYCLES`: FAIL, code 2.
  3. Stall counter reaches `STALL_LIMIT`: FAIL, code 3.
- PASS and FAIL are absorbing until `reset`. All retire and writeback inputs are ignored there and in HOLD.
- `passed` and `failed` are never both 1. `fail_code` is 0 whenever `failed`=0.
- Arithmetic: all counters 32-bit unsigned with saturating increment, so there is no wrap.

## Timing
- All outputs registered. Verdict outputs (`passed`/`failed`, `fail_code`, `fail_cycle`) update on the clock edge after the triggering input cycle. `fail_cycle` takes `cyc_cnt` sampled in the triggering cycle.
- `cpu_reset` falls exactly `RST_HOLD` cycles after the first cycle with `reset` low.
- Timeout fires on the `MAX_CYCLES`-th RUN cycle. Stall fires on the `STALL_LIMIT`-th consecutive non-retiring cycle.
- Reset mid-RUN, or in PASS/FAIL, returns to HOLD on the next edge. All state clears and `cpu_reset` reasserts.
- A halt coinciding with timeout or stall in the same cycle resolves as halt.

## Test plan
- Reset released at cycle 5, `RST_HOLD`=4 → `cpu_reset` high through cycle 8 and low from cycle 9. `passed`/`failed` stay 0.
- Writeback x10=1, then PC 0x40 retired 3 times consecutively → `passed`=1 one cycle after the third retire, `fail_code`=0. Further inputs are ignored.
- Writeback x10=0x2, then halt at 0x80 → `failed`=1, `fail_code`=1, `fail_cycle` = `cyc_cnt` of the third retire.
- Alternating PCs 0x10/0x14, `MAX_CYCLES`=50 → `failed`=1, `fail_code`=2 after 50 RUN cycles.
- No retirements, `STALL_LIMIT`=8 → `fail_code`=3 after 8 RUN cycles. A third same-PC retire with x10=1 landing on the same cycle as timeout → PASS.
- Assert `reset` for 1 cycle while in FAIL → outputs clear, HOLD re-entered, `cpu_reset`=1, and a fresh pass sequence then yields `passed`=1.
